// File: rtl/ex_wb_pipe_reg.sv
// EX->WB elastic pipeline stage: a two-entry skid buffer feeding write-back and fetch redirect.
// Write-back data and redirect are resolved combinationally from the registered head record.
module ex_wb_pipe_reg #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 6,
    parameter int WBC_W   = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WBC_W-1:0]   wbc_in,
    input  logic               regWrt_in,
    input  logic               branchZero_in,
    input  logic               branchNeg_in,
    input  logic               jump_in,
    input  logic               jumpMem_in,
    input  logic               z_in,
    input  logic               n_in,
    input  logic [RADDR_W-1:0] rd_in,
    input  logic [DATA_W-1:0]  pc_plus_y_in,
    input  logic [DATA_W-1:0]  xrs_in,
    input  logic [DATA_W-1:0]  readData_in,
    input  logic [DATA_W-1:0]  aluResult_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [RADDR_W-1:0] rd_out,
    output logic               reg_we,
    output logic [DATA_W-1:0]  wb_data,
    output logic               redirect_valid,
    output logic [DATA_W-1:0]  redirect_target
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [WBC_W-1:0]   wbc;
        logic               regWrt;
        logic               branchZero;
        logic               branchNeg;
        logic               jump;
        logic               jumpMem;
        logic               z;
        logic               n;
        logic [RADDR_W-1:0] rd;
        logic [DATA_W-1:0]  pc_plus_y;
        logic [DATA_W-1:0]  xrs;
        logic [DATA_W-1:0]  readData;
        logic [DATA_W-1:0]  aluResult;
    } rec_t;

    state_t state_q, state_d;
    rec_t   head_q, head_d;
    rec_t   skid_q, skid_d;
    rec_t   in_rec;
    logic   accept;
    logic   pop;
    logic   taken;

    always_comb begin
        in_rec            = '0;
        in_rec.wbc        = wbc_in;
        in_rec.regWrt     = regWrt_in;
        in_rec.branchZero = branchZero_in;
        in_rec.branchNeg  = branchNeg_in;
        in_rec.jump       = jump_in;
        in_rec.jumpMem    = jumpMem_in;
        in_rec.z          = z_in;
        in_rec.n          = n_in;
        in_rec.rd         = rd_in;
        in_rec.pc_plus_y  = pc_plus_y_in;
        in_rec.xrs        = xrs_in;
        in_rec.readData   = readData_in;
        in_rec.aluResult  = aluResult_in;
    end

    // Handshake depends only on registered state, so in_ready never sees out_ready.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        head_d  = in_rec;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        head_d = in_rec;
                    end else if (accept) begin
                        skid_d  = in_rec;
                        state_d = FULL;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        case (head_q.wbc)
            WBC_W'(0): wb_data = head_q.aluResult;
            WBC_W'(1): wb_data = head_q.readData;
            WBC_W'(2): wb_data = head_q.pc_plus_y;
            default:   wb_data = head_q.xrs;
        endcase
    end

    assign taken = head_q.jump | head_q.jumpMem
                 | (head_q.branchZero & head_q.z)
                 | (head_q.branchNeg & head_q.n);

    // Memory-indirect jump wins over register-indirect targets.
    always_comb begin
        if (head_q.jumpMem)
            redirect_target = head_q.readData;
        else if (head_q.jump | head_q.branchZero | head_q.branchNeg)
            redirect_target = head_q.xrs;
        else
            redirect_target = head_q.pc_plus_y;
    end

    assign redirect_valid = out_valid & taken;
    assign reg_we         = out_valid & head_q.regWrt;
    assign rd_out         = head_q.rd;

endmodule

// File: tb/tb_ex_wb_pipe_reg.sv
// Directed bench for ex_wb_pipe_reg: inputs change and outputs are sampled on the falling edge.
module tb_ex_wb_pipe_reg;

    localparam int DATA_W  = 32;
    localparam int RADDR_W = 6;
    localparam int WBC_W   = 2;

    logic               clock = 1'b0;
    logic               reset, flush, in_valid, in_ready;
    logic [WBC_W-1:0]   wbc_in;
    logic               regWrt_in, branchZero_in, branchNeg_in, jump_in, jumpMem_in, z_in, n_in;
    logic [RADDR_W-1:0] rd_in;
    logic [DATA_W-1:0]  pc_plus_y_in, xrs_in, readData_in, aluResult_in;
    logic               out_valid, out_ready, reg_we, redirect_valid;
    logic [RADDR_W-1:0] rd_out;
    logic [DATA_W-1:0]  wb_data, redirect_target;

    int n_chk  = 0;
    int n_fail = 0;

    ex_wb_pipe_reg #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .WBC_W(WBC_W)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .wbc_in(wbc_in), .regWrt_in(regWrt_in), .branchZero_in(branchZero_in),
        .branchNeg_in(branchNeg_in), .jump_in(jump_in), .jumpMem_in(jumpMem_in),
        .z_in(z_in), .n_in(n_in), .rd_in(rd_in),
        .pc_plus_y_in(pc_plus_y_in), .xrs_in(xrs_in),
        .readData_in(readData_in), .aluResult_in(aluResult_in),
        .out_valid(out_valid), .out_ready(out_ready), .rd_out(rd_out),
        .reg_we(reg_we), .wb_data(wb_data),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        in_valid = 0; wbc_in = '0; regWrt_in = 0; branchZero_in = 0; branchNeg_in = 0;
        jump_in = 0; jumpMem_in = 0; z_in = 0; n_in = 0; rd_in = '0;
        pc_plus_y_in = '0; xrs_in = '0; readData_in = '0; aluResult_in = '0;
    endtask

    task automatic push_alu(input logic [31:0] v);
        clr_in();
        in_valid = 1; aluResult_in = v; regWrt_in = 1;
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    logic [31:0] sweep [4];

    initial begin
        reset = 1; flush = 0; out_ready = 0;
        clr_in();
        tick(); tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_reg_we", reg_we, 0);
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_redirect_target", redirect_target, 0);
        chk("rst_rd_out", rd_out, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 0;

        // 1: single record, one-cycle latency
        clr_in();
        in_valid = 1; aluResult_in = 32'hAA; regWrt_in = 1; rd_in = 6'd5; out_ready = 1;
        tick();
        clr_in();
        chk("t1_out_valid", out_valid, 1);
        chk("t1_wb_data", wb_data, 32'hAA);
        chk("t1_reg_we", reg_we, 1);
        chk("t1_rd_out", rd_out, 5);
        tick();
        chk("t1_drained", out_valid, 0);
        chk("t1_reg_we_gated", reg_we, 0);

        // 2: backpressure, FIFO order, no loss
        out_ready = 0;
        push_alu(32'd1);
        tick();
        chk("t2_ready_after_A", in_ready, 1);
        push_alu(32'd2);
        tick();
        chk("t2_ready_full", in_ready, 0);
        push_alu(32'd3);
        tick();
        chk("t2_hold_valid", out_valid, 1);
        chk("t2_hold_A", wb_data, 1);
        chk("t2_hold_ready", in_ready, 0);
        out_ready = 1;
        tick();
        chk("t2_pop_B", wb_data, 2);
        chk("t2_ready_one", in_ready, 1);
        tick();
        clr_in();
        chk("t2_pop_C", wb_data, 3);
        chk("t2_C_valid", out_valid, 1);
        tick();
        chk("t2_empty", out_valid, 0);

        // 3: branch / jump redirect
        clr_in();
        in_valid = 1; branchNeg_in = 1; n_in = 1; xrs_in = 32'h40; pc_plus_y_in = 32'h100;
        tick();
        chk("t3_bn_taken", redirect_valid, 1);
        chk("t3_bn_target", redirect_target, 32'h40);
        clr_in();
        in_valid = 1; branchNeg_in = 1; n_in = 0; z_in = 1; xrs_in = 32'h40; pc_plus_y_in = 32'h104;
        tick();
        chk("t3_bn_not_taken", redirect_valid, 0);
        chk("t3_bn_nt_target", redirect_target, 32'h40);
        clr_in();
        in_valid = 1; jumpMem_in = 1; jump_in = 1; readData_in = 32'h1234; xrs_in = 32'h40;
        tick();
        clr_in();
        chk("t3_jm_taken", redirect_valid, 1);
        chk("t3_jm_target", redirect_target, 32'h1234);
        tick();
        chk("t3_stale_gated", redirect_valid, 0);

        // 4: flush while FULL, and flush while empty drops the input
        out_ready = 0;
        push_alu(32'h55); jump_in = 1;
        tick();
        push_alu(32'h66);
        tick();
        chk("t4_full", in_ready, 0);
        push_alu(32'h77);
        flush = 1;
        tick();
        flush = 0;
        clr_in();
        chk("t4_out_valid", out_valid, 0);
        chk("t4_reg_we", reg_we, 0);
        chk("t4_redirect_valid", redirect_valid, 0);
        chk("t4_in_ready", in_ready, 1);
        out_ready = 1;
        tick();
        chk("t4_stays_empty", out_valid, 0);
        push_alu(32'h88);
        flush = 1;
        tick();
        flush = 0;
        clr_in();
        chk("t4_drop_input", out_valid, 0);

        // 5: reset overrides flush mid-stream
        out_ready = 0;
        push_alu(32'h5A); rd_in = 6'd33; jump_in = 1; xrs_in = 32'hF0;
        tick();
        push_alu(32'h5B);
        tick();
        push_alu(32'h5C);
        reset = 1; flush = 1;
        tick();
        reset = 0; flush = 0;
        clr_in();
        chk("t5_out_valid", out_valid, 0);
        chk("t5_reg_we", reg_we, 0);
        chk("t5_redirect_valid", redirect_valid, 0);
        chk("t5_wb_data", wb_data, 0);
        chk("t5_redirect_target", redirect_target, 0);
        chk("t5_rd_out", rd_out, 0);
        chk("t5_in_ready", in_ready, 1);
        out_ready = 1;
        push_alu(32'h99); rd_in = 6'd63;
        tick();
        clr_in();
        chk("t5_new_valid", out_valid, 1);
        chk("t5_new_data", wb_data, 32'h99);
        chk("t5_new_rd", rd_out, 63);
        tick();

        // 6: wbc sweep at full throughput
        sweep[0] = 32'h11; sweep[1] = 32'h22; sweep[2] = 32'h33; sweep[3] = 32'h44;
        for (int k = 0; k < 4; k++) begin
            clr_in();
            in_valid = 1; wbc_in = WBC_W'(k);
            aluResult_in = 32'hA0; readData_in = 32'hB0; pc_plus_y_in = 32'hC0; xrs_in = 32'hD0;
            case (k)
                0: aluResult_in = sweep[0];
                1: readData_in  = sweep[1];
                2: pc_plus_y_in = sweep[2];
                default: xrs_in = sweep[3];
            endcase
            tick();
            chk($sformatf("t6_valid_%0d", k), out_valid, 1);
            chk($sformatf("t6_wb_data_%0d", k), wb_data, sweep[k]);
            chk($sformatf("t6_in_ready_%0d", k), in_ready, 1);
        end
        clr_in();
        tick();
        chk("t6_drained", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
